// File: rtl/mc_switch_param.sv
// Multicast NoC switch: per-input FIFOs, full crossbar, one round-robin arbiter per output.
// Multicast heads fork to free outputs independently and pop once every destination is served.
module mc_switch_param #(
  parameter int unsigned NPORTS   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned DATASIZE = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS*DATASIZE-1:0] in_data,
  input  logic [NPORTS-1:0]          in_valid,
  output logic [NPORTS-1:0]          in_full,
  output logic [NPORTS*DATASIZE-1:0] out_data,
  output logic [NPORTS-1:0]          out_valid,
  input  logic [NPORTS-1:0]          out_full,
  output logic                       overflow
);

  localparam int unsigned RrW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [DATASIZE-1:0]        mem_q     [NPORTS][DEPTH];
  logic [DATASIZE-1:0]        mem_d     [NPORTS][DEPTH];
  logic [WIDTH-1:0]           wr_ptr_q  [NPORTS];
  logic [WIDTH-1:0]           wr_ptr_d  [NPORTS];
  logic [WIDTH-1:0]           rd_ptr_q  [NPORTS];
  logic [WIDTH-1:0]           rd_ptr_d  [NPORTS];
  logic [WIDTH:0]             count_q   [NPORTS];
  logic [WIDTH:0]             count_d   [NPORTS];
  logic [NPORTS-1:0]          served_q  [NPORTS];
  logic [NPORTS-1:0]          served_d  [NPORTS];
  logic [RrW-1:0]             rr_q      [NPORTS];
  logic [RrW-1:0]             rr_d      [NPORTS];
  logic [NPORTS-1:0]          out_valid_q, out_valid_d;
  logic [NPORTS*DATASIZE-1:0] out_data_q, out_data_d;
  logic                       overflow_q, overflow_d;

  logic [DATASIZE-1:0] head     [NPORTS];
  logic [NPORTS-1:0]   req      [NPORTS];  // req[i][j]: input i wants output j
  logic [NPORTS-1:0]   gnt      [NPORTS];  // gnt[i][j]: input i won output j
  logic [RrW-1:0]      gnt_src  [NPORTS];
  logic [NPORTS-1:0]   gnt_out;
  logic [NPORTS-1:0]   nonempty, full, push, pop;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      nonempty[i] = (count_q[i] != '0);
      full[i]     = (count_q[i] == (WIDTH+1)'(DEPTH));
      head[i]     = mem_q[i][rd_ptr_q[i]];
      push[i]     = in_valid[i] & ~full[i];
      req[i]      = {NPORTS{nonempty[i]}} & head[i][NPORTS-1:0] & ~served_q[i];
    end
  end

  // Per-output round-robin scan starting at rr_q[j]; one grant per output.
  always_comb begin
    int unsigned idx;
    idx = 0;
    gnt_out = '0;
    for (int i = 0; i < NPORTS; i++) begin
      gnt[i]     = '0;
      gnt_src[i] = '0;
    end
    for (int j = 0; j < NPORTS; j++) begin
      if (!out_full[j]) begin
        for (int unsigned k = 0; k < NPORTS; k++) begin
          idx = (32'(rr_q[j]) + k) % NPORTS;
          if (!gnt_out[j] && req[idx][j]) begin
            gnt[idx][j] = 1'b1;
            gnt_out[j]  = 1'b1;
            gnt_src[j]  = RrW'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    served_d    = served_q;
    rr_d        = rr_q;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | (|(in_valid & full));
    pop         = '0;

    for (int j = 0; j < NPORTS; j++) begin
      if (gnt_out[j]) begin
        out_valid_d[j]                     = 1'b1;
        out_data_d[j*DATASIZE +: DATASIZE] = head[gnt_src[j]];
        rr_d[j] = (gnt_src[j] == RrW'(NPORTS - 1)) ? '0 : gnt_src[j] + RrW'(1);
      end
    end

    for (int i = 0; i < NPORTS; i++) begin
      // A zero-mask head is trivially done and drops silently.
      pop[i] = nonempty[i] &
               ((head[i][NPORTS-1:0] & ~(served_q[i] | gnt[i])) == '0);
      if (pop[i]) begin
        served_d[i] = '0;
        rd_ptr_d[i] = rd_ptr_q[i] + WIDTH'(1);
      end else begin
        served_d[i] = served_q[i] | gnt[i];
      end
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i*DATASIZE +: DATASIZE];
        wr_ptr_d[i]           = wr_ptr_q[i] + WIDTH'(1);
      end
      unique case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + (WIDTH+1)'(1);
        2'b01:   count_d[i] = count_q[i] - (WIDTH+1)'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        served_q[i] <= '0;
        rr_q[i]     <= '0;
      end
      out_valid_q <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      served_q    <= served_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_full   = full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mc_switch_param.sv
// Directed bench for mc_switch_param (NPORTS=5, DEPTH=4, DATASIZE=30).
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_mc_switch_param;

  localparam int unsigned NP = 5;
  localparam int unsigned DS = 30;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*DS-1:0] in_data;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_full;
  logic [NP*DS-1:0] out_data;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_full;
  logic             overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mc_switch_param #(
    .NPORTS  (NP),
    .DEPTH   (4),
    .WIDTH   (2),
    .DATASIZE(DS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_full  (in_full),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_full (out_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [DS-1:0] f);
    in_data[p*DS +: DS] = f;
    in_valid[p]         = 1'b1;
  endtask

  function automatic logic [63:0] od(input int p);
    return 64'(out_data[p*DS +: DS]);
  endfunction

  logic [DS-1:0] f1, f2, fb, fc, f5;

  initial begin
    in_data  = '0;
    in_valid = '0;
    out_full = '0;
    rst_n    = 1'b0;
    repeat (2) step();
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_out_data",  64'(|out_data), 64'h0);
    check_eq("rst_in_full",   64'(in_full),   64'h0);
    check_eq("rst_overflow",  64'(overflow),  64'h0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("post_rst_in_full",   64'(in_full),   64'h0);

    // Unicast port 1 -> output 2, two-cycle latency
    f1 = 30'h1234_5004;
    put(1, f1);
    step(); in_valid = '0;
    check_eq("t1_early", 64'(out_valid), 64'h0);
    step();
    check_eq("t1_valid", 64'(out_valid), 64'h04);
    check_eq("t1_data",  od(2), 64'(f1));
    step();
    check_eq("t1_pulse", 64'(out_valid), 64'h0);

    // Multicast port 0 -> outputs 1..4 in one cycle
    f2 = 30'h0AB0_001E;
    put(0, f2);
    step(); in_valid = '0;
    check_eq("t2_early", 64'(out_valid), 64'h0);
    step();
    check_eq("t2_fork", 64'(out_valid), 64'h1E);
    for (int p = 1; p < 5; p++) check_eq("t2_data", od(p), 64'(f2));
    step();
    check_eq("t2_pop_once", 64'(out_valid), 64'h0);

    // Multicast with output 3 blocked for 3 cycles; next flit waits behind it
    fb = 30'h0CD0_0002;
    put(0, f2);
    step(); in_valid = '0;
    put(0, fb);
    out_full[3] = 1'b1;
    step(); in_valid = '0;
    check_eq("t3_partial", 64'(out_valid), 64'h16);
    step();
    check_eq("t3_blocked_a", 64'(out_valid), 64'h0);
    step();
    out_full[3] = 1'b0;
    check_eq("t3_blocked_b", 64'(out_valid), 64'h0);
    step();
    check_eq("t3_late_out3", 64'(out_valid), 64'h08);
    check_eq("t3_late_data", od(3), 64'(f2));
    step();
    check_eq("t3_next_flit", 64'(out_valid), 64'h02);
    check_eq("t3_next_data", od(1), 64'(fb));
    step();
    check_eq("t3_idle", 64'(out_valid), 64'h0);

    // Ports 1..4 contend for output 0 every cycle
    for (int c = 0; c < 12; c++) begin
      in_valid = '0;
      if (c == 4) check_eq("t4_in_full", 64'(in_full), 64'h10);
      if (c >= 2 && c < 10) begin
        check_eq("t4_valid", 64'(out_valid[0]), 64'h1);
        check_eq("t4_rr_port", (od(0) >> 20) & 64'h7, 64'((c - 2) % 4 + 1));
      end
      if (c < 10) begin
        for (int p = 1; p < 5; p++) begin
          if (!in_full[p]) put(p, 30'((p << 20) | (c << 8) | 1));
        end
      end
      step();
    end
    in_valid = '0;
    repeat (24) step();
    check_eq("t4_drained_valid", 64'(out_valid), 64'h0);
    check_eq("t4_drained_full",  64'(in_full),   64'h0);

    // Fill FIFO 1 while output 2 is blocked, then overflow it
    out_full[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(1, 30'(32'h0100_0004 | (k << 8)));
      step(); in_valid = '0;
    end
    check_eq("t5_in_full",   64'(in_full),   64'h02);
    check_eq("t5_no_ovf",    64'(overflow),  64'h0);
    check_eq("t5_held",      64'(out_valid), 64'h0);
    f5 = 30'h0100_0F04;
    put(1, f5);
    step(); in_valid = '0;
    check_eq("t5_overflow", 64'(overflow), 64'h1);
    out_full[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t5_drain_valid", 64'(out_valid), 64'h04);
      check_eq("t5_drain_data",  od(2), 64'(32'h0100_0004 | (k << 8)));
    end
    step();
    check_eq("t5_dropped", 64'(out_valid), 64'h0);
    check_eq("t5_sticky",  64'(overflow),  64'h1);

    // Zero-mask flit is dropped silently ahead of a unicast
    fc = 30'h0300_1002;
    put(3, 30'h0300_0000);
    step(); in_valid = '0;
    put(3, fc);
    check_eq("t6_none_a", 64'(out_valid), 64'h0);
    step(); in_valid = '0;
    check_eq("t6_none_b", 64'(out_valid), 64'h0);
    step();
    check_eq("t6_uni_valid", 64'(out_valid), 64'h02);
    check_eq("t6_uni_data",  od(1), 64'(fc));
    step();
    check_eq("t6_idle", 64'(out_valid), 64'h0);

    // Reset asserted mid-flight clears outputs immediately
    put(2, 30'h0200_0001);
    step(); in_valid = '0;
    step();
    check_eq("t7_pre_valid", 64'(out_valid), 64'h01);
    rst_n = 1'b0;
    #1;
    check_eq("t7_async_valid", 64'(out_valid), 64'h0);
    check_eq("t7_async_data",  64'(|out_data), 64'h0);
    check_eq("t7_async_ovf",   64'(overflow),  64'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("t7_after", 64'(out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
